// File: rtl/parity_serial_receiver_pkg.sv
// ---------------------------------------------------------------------------
// parity_link_pkg
//   Shared definitions for the slow-clock parity serial link receiver:
//   default frame geometry, parity sense, error counter width, FSM encoding
//   and the bit counter width derived from the frame width.
// ---------------------------------------------------------------------------
package parity_link_pkg;

   localparam int PKG_DATA_W    = 7;
   localparam int PKG_FRAME_W   = PKG_DATA_W + 1;
   localparam int PKG_ODD_PAR   = 1;
   localparam int PKG_ERR_CNT_W = 8;

   // Bit counter counts 0..FRAME_W-1
   localparam int PKG_BIT_CNT_W = $clog2(PKG_FRAME_W);

   // Binary encoded receive FSM
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } rx_state_t;

endpackage

// File: rtl/parity_serial_receiver_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up counter that sticks at all-ones instead of wrapping.
//   Ports:
//     i_clk    clock, posedge
//     i_rst_n  synchronous reset, active-low (clears count)
//     i_inc    increment request for this cycle
//     o_count  current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_count <= '0;
      else if (i_inc && (r_count != {W{1'b1}}))
         r_count <= r_count + W'(1);
   end

   assign o_count = r_count;

endmodule

// File: rtl/parity_serial_receiver.sv
// ---------------------------------------------------------------------------
// parity_serial_receiver
//   Receiving end of the slow-clock parity serial link. Shifts in one frame
//   LSB-first (DATA_W data bits then a parity bit), checks parity over the
//   whole frame, presents the result and pulses data_valid for one cycle.
//   Ports:
//     CLK100MHZ     system clock, posedge
//     resetSW_n     synchronous reset, active-low
//     bit_tick      bit-rate enable; serial_in sampled when high (SHIFT only)
//     frame_start   strobe: the next accepted tick samples frame bit 0
//     serial_in     serial data line, LSB first
//     data_out      data bits of the last completed frame
//     parity_out    received parity bit of the last completed frame
//     parity_err    last completed frame failed the parity check
//     data_valid    one-cycle pulse when the result outputs update
//     busy          high while in SHIFT or CHECK
//     restart_flag  sticky: a frame was restarted mid-frame
//     err_count     saturating count of frames with a parity error
// ---------------------------------------------------------------------------
module parity_serial_receiver
   import parity_link_pkg::*;
#(
   parameter int DATA_W    = PKG_DATA_W,
   parameter int ODD_PAR   = PKG_ODD_PAR,
   parameter int ERR_CNT_W = PKG_ERR_CNT_W
) (
   input  logic                 CLK100MHZ,
   input  logic                 resetSW_n,
   input  logic                 bit_tick,
   input  logic                 frame_start,
   input  logic                 serial_in,
   output logic [DATA_W-1:0]    data_out,
   output logic                 parity_out,
   output logic                 parity_err,
   output logic                 data_valid,
   output logic                 busy,
   output logic                 restart_flag,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int FRAME_W = DATA_W + 1;
   localparam int CNT_W   = $clog2(FRAME_W);

   rx_state_t          r_state;
   logic [FRAME_W-1:0] r_sreg;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic [DATA_W-1:0]  r_data;
   logic               r_parity;
   logic               r_perr;
   logic               r_valid;
   logic               r_busy;
   logic               r_restart;

   rx_state_t          w_state_nxt;
   logic               w_shift;
   logic               w_cnt_clr;
   logic               w_restart;
   logic               w_load;
   logic [FRAME_W-1:0] w_sreg_nxt;
   logic               w_err;

   // Frame content as it will be once the current bit is shifted in
   assign w_sreg_nxt = {serial_in, r_sreg[FRAME_W-1:1]};
   assign w_err      = (^w_sreg_nxt) != 1'(ODD_PAR);

   // Next-state and control decode
   always_comb begin
      w_state_nxt = r_state;
      w_shift     = 1'b0;
      w_cnt_clr   = 1'b0;
      w_restart   = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A tick coincident with frame_start is deliberately not sampled
            if (frame_start) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_clr   = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (frame_start) begin
               // Abort: the coincident tick is dropped, bit 0 comes next
               w_cnt_clr = 1'b1;
               w_restart = 1'b1;
            end else if (bit_tick) begin
               w_shift = 1'b1;
               if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
                  w_state_nxt = ST_CHECK;
                  // Results are captured on the same edge as the last bit so
                  // they are visible together with data_valid in CHECK
                  w_load      = 1'b1;
               end
            end
         end
         ST_CHECK: begin
            if (frame_start) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_clr   = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge CLK100MHZ) begin
      if (!resetSW_n) begin
         r_state   <= ST_IDLE;
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_data    <= '0;
         r_parity  <= 1'b0;
         r_perr    <= 1'b0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_restart <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_valid <= w_load;

         if (w_cnt_clr)
            r_bit_cnt <= '0;
         else if (w_shift)
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);

         if (w_shift)
            r_sreg <= w_sreg_nxt;

         if (w_load) begin
            r_data   <= w_sreg_nxt[DATA_W-1:0];
            r_parity <= w_sreg_nxt[FRAME_W-1];
            r_perr   <= w_err;
         end

         if (w_restart)
            r_restart <= 1'b1;
      end
   end

   sat_counter #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .i_clk   (CLK100MHZ),
      .i_rst_n (resetSW_n),
      .i_inc   (w_load && w_err),
      .o_count (err_count)
   );

   assign data_out     = r_data;
   assign parity_out   = r_parity;
   assign parity_err   = r_perr;
   assign data_valid   = r_valid;
   assign busy         = r_busy;
   assign restart_flag = r_restart;

endmodule
